// File: rtl/paula_audio_dma_scheduler_if.sv
// Slot handshake between the audio DMA scheduler and the DMA engine.
// Latency: none (wires only).
// Backpressure: engine holds off grants with slot_free=0 and completes them with slot_ack.
interface paula_audio_dma_scheduler_if;
    logic       slot_req;
    logic [1:0] slot_chan;
    logic       slot_restart;
    logic       slot_free;
    logic       slot_ack;

    modport master (
        output slot_req,
        output slot_chan,
        output slot_restart,
        input  slot_free,
        input  slot_ack
    );

    modport slave (
        input  slot_req,
        input  slot_chan,
        input  slot_restart,
        output slot_free,
        output slot_ack
    );
endinterface

// File: rtl/paula_audio_dma_scheduler.sv
// Latches per-line audio DMA requests and grants them one at a time, lowest channel first.
// Latency: grant registered one clk7_en edge after SCAN sees cck & slot_free; strhor is combinational.
// Backpressure: no grant without cck & slot_free; a grant is held until slot_ack.
module paula_audio_dma_scheduler (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clk7_en,
    input  logic                               cck,
    input  logic                               line_strobe,
    input  logic                               dmaen_master,
    input  logic [3:0]                         aud_dmaen,
    input  logic [3:0]                         dmareq,
    input  logic [3:0]                         dmas,
    input  logic                               ovr_clr,
    paula_audio_dma_scheduler_if.master        slot,
    output logic                               strhor,
    output logic [3:0]                         pending,
    output logic [3:0]                         overrun,
    output logic                               busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_pending;
    logic [3:0] w_pending_nxt;
    logic [3:0] r_restart;
    logic [3:0] w_restart_nxt;
    logic [3:0] r_overrun;
    logic [3:0] w_overrun_nxt;
    logic [3:0] w_ovr_set;
    logic       r_slot_req;
    logic       w_slot_req_nxt;
    logic [1:0] r_slot_chan;
    logic [1:0] w_slot_chan_nxt;
    logic       r_slot_restart;
    logic       w_slot_restart_nxt;
    logic [3:0] w_lat_req;
    logic [3:0] w_lat_rst;
    logic [3:0] w_chan_mask;
    logic [1:0] w_lowest;

    // Requests that survive the global and per-channel enables at the line strobe.
    assign w_lat_req   = dmareq & aud_dmaen & {4{dmaen_master}};
    assign w_lat_rst   = dmas   & aud_dmaen & {4{dmaen_master}};
    // One-hot of the channel currently granted (meaningful in WAIT).
    assign w_chan_mask = 4'b0001 << r_slot_chan;

    // Channels clear their request on the same edge this block latches it.
    assign strhor = line_strobe & clk7_en & ~reset;

    assign slot.slot_req     = r_slot_req;
    assign slot.slot_chan    = r_slot_chan;
    assign slot.slot_restart = r_slot_restart;
    assign pending           = r_pending;
    assign overrun           = r_overrun;
    assign busy              = (r_state != ST_IDLE);

    // Lowest-numbered pending channel wins the next slot.
    always_comb begin
        w_lowest = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lowest = 2'(i);
            end
        end
    end

    // Next-state, pending bookkeeping and grant outputs.
    always_comb begin
        w_state_nxt        = r_state;
        w_pending_nxt      = r_pending;
        w_restart_nxt      = r_restart;
        w_ovr_set          = 4'h0;
        w_slot_req_nxt     = r_slot_req;
        w_slot_chan_nxt    = r_slot_chan;
        w_slot_restart_nxt = r_slot_restart;
        case (r_state)
            ST_IDLE: begin
                if (line_strobe) begin
                    w_pending_nxt = w_lat_req;
                    w_restart_nxt = w_lat_rst;
                    if (|w_lat_req) begin
                        w_state_nxt = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                // A new line replaces anything not yet granted; the leftovers are overruns.
                if (line_strobe) begin
                    w_ovr_set     = r_pending;
                    w_pending_nxt = w_lat_req;
                    w_restart_nxt = w_lat_rst;
                end else if (!dmaen_master || (r_pending == 4'h0)) begin
                    w_pending_nxt = 4'h0;
                    w_restart_nxt = 4'h0;
                    w_state_nxt   = ST_IDLE;
                end else if (cck && slot.slot_free) begin
                    w_slot_req_nxt     = 1'b1;
                    w_slot_chan_nxt    = w_lowest;
                    w_slot_restart_nxt = r_restart[w_lowest];
                    w_state_nxt        = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The in-flight channel is not an overrun; on a coincident ack the new latch wins.
                if (line_strobe) begin
                    w_ovr_set     = r_pending & ~w_chan_mask;
                    w_pending_nxt = w_lat_req;
                    w_restart_nxt = w_lat_rst;
                end else if (slot.slot_ack) begin
                    w_pending_nxt = r_pending & ~w_chan_mask;
                    w_restart_nxt = r_restart & ~w_chan_mask;
                end
                if (slot.slot_ack) begin
                    w_slot_req_nxt = 1'b0;
                    w_state_nxt    = ST_SCAN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A same-cycle set beats the clear.
        w_overrun_nxt = (ovr_clr ? 4'h0 : r_overrun) | w_ovr_set;
    end

    // State register, gated by the 7 MHz enable; reset also waits for the enable.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                r_state        <= ST_IDLE;
                r_pending      <= 4'h0;
                r_restart      <= 4'h0;
                r_overrun      <= 4'h0;
                r_slot_req     <= 1'b0;
                r_slot_chan    <= 2'd0;
                r_slot_restart <= 1'b0;
            end else begin
                r_state        <= w_state_nxt;
                r_pending      <= w_pending_nxt;
                r_restart      <= w_restart_nxt;
                r_overrun      <= w_overrun_nxt;
                r_slot_req     <= w_slot_req_nxt;
                r_slot_chan    <= w_slot_chan_nxt;
                r_slot_restart <= w_slot_restart_nxt;
            end
        end
    end

endmodule

// File: tb/tb_paula_audio_dma_scheduler.sv
// Bench for the audio DMA scheduler: directed scenarios, then randomized traffic against a line-level model.
// Latency: outputs compared 1 time unit after each clock edge; strhor compared within the cycle.
// Backpressure: slot_free, cck and slot_ack are driven by the bench.
module tb_paula_audio_dma_scheduler;

    logic       clk = 1'b0;
    logic       reset, clk7_en, cck, line_strobe, dmaen_master, ovr_clr;
    logic [3:0] aud_dmaen, dmareq, dmas;
    logic       strhor, busy;
    logic [3:0] pending, overrun;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    paula_audio_dma_scheduler_if u_if ();

    paula_audio_dma_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .clk7_en      (clk7_en),
        .cck          (cck),
        .line_strobe  (line_strobe),
        .dmaen_master (dmaen_master),
        .aud_dmaen    (aud_dmaen),
        .dmareq       (dmareq),
        .dmas         (dmas),
        .ovr_clr      (ovr_clr),
        .slot         (u_if.master),
        .strhor       (strhor),
        .pending      (pending),
        .overrun      (overrun),
        .busy         (busy)
    );

    // Reference model: a line's request set, whether work is outstanding, and the one grant in flight.
    bit       m_busy, m_inflight, m_req, m_rest;
    bit [1:0] m_chan;
    bit [3:0] m_pend, m_rst, m_ovr;

    function automatic bit [1:0] first_set(input bit [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    always @(posedge clk) begin : model
        bit [3:0] lat, latr, setv, keep;
        if (clk7_en) begin
            if (reset) begin
                m_busy = 0; m_inflight = 0; m_req = 0; m_rest = 0;
                m_chan = 0; m_pend = 0; m_rst = 0; m_ovr = 0;
            end else begin
                lat  = dmareq & aud_dmaen & {4{dmaen_master}};
                latr = dmas & aud_dmaen & {4{dmaen_master}};
                setv = 4'h0;
                keep = ovr_clr ? 4'h0 : m_ovr;
                if (m_inflight) begin
                    if (line_strobe) begin
                        setv   = m_pend & ~(4'b0001 << m_chan);
                        m_pend = lat;
                        m_rst  = latr;
                    end else if (u_if.slot_ack) begin
                        m_pend[m_chan] = 1'b0;
                        m_rst[m_chan]  = 1'b0;
                    end
                    if (u_if.slot_ack) begin
                        m_inflight = 0;
                        m_req      = 0;
                    end
                end else if (m_busy) begin
                    if (line_strobe) begin
                        setv   = m_pend;
                        m_pend = lat;
                        m_rst  = latr;
                    end else if (!dmaen_master || m_pend == 4'h0) begin
                        m_pend = 0; m_rst = 0; m_busy = 0;
                    end else if (cck && u_if.slot_free) begin
                        m_chan     = first_set(m_pend);
                        m_rest     = m_rst[m_chan];
                        m_req      = 1;
                        m_inflight = 1;
                    end
                end else if (line_strobe) begin
                    m_pend = lat;
                    m_rst  = latr;
                    m_busy = (lat != 4'h0);
                end
                m_ovr = keep | setv;
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_model();
        chk("model_slot_req",     8'(u_if.slot_req),     8'(m_req));
        chk("model_slot_chan",    8'(u_if.slot_chan),    8'(m_chan));
        chk("model_slot_restart", 8'(u_if.slot_restart), 8'(m_rest));
        chk("model_pending",      8'(pending),           8'(m_pend));
        chk("model_overrun",      8'(overrun),           8'(m_ovr));
        chk("model_busy",         8'(busy),              8'(m_busy | m_inflight));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic strobe_line(input logic [3:0] req, input logic [3:0] rst);
        dmareq = req; dmas = rst; line_strobe = 1'b1;
        #1;
        chk("strhor_on_strobe", 8'(strhor), 8'(clk7_en & ~reset));
        step();
        line_strobe = 1'b0; dmareq = 4'h0; dmas = 4'h0;
    endtask

    task automatic ack_grant();
        u_if.slot_ack = 1'b1;
        step();
        chk("req_drop_on_ack", 8'(u_if.slot_req), 8'h00);
        u_if.slot_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clk7_en = 1'b1; cck = 1'b1; line_strobe = 1'b1; dmaen_master = 1'b1;
        ovr_clr = 1'b0; aud_dmaen = 4'hF; dmareq = 4'hF; dmas = 4'h0;
        u_if.slot_free = 1'b1; u_if.slot_ack = 1'b0;
        #1;
        chk("strhor_in_reset", 8'(strhor), 8'h00);
        @(posedge clk); #1;
        step();
        chk("rst_slot_req", 8'(u_if.slot_req), 8'h00);
        chk("rst_slot_chan", 8'(u_if.slot_chan), 8'h00);
        chk("rst_pending", 8'(pending), 8'h00);
        chk("rst_overrun", 8'(overrun), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        reset = 1'b0; line_strobe = 1'b0; dmareq = 4'h0;

        // Two channels in one line, granted lowest first.
        strobe_line(4'b1010, 4'b0000);
        chk("s1_pending", 8'(pending), 8'h0A);
        chk("s1_busy", 8'(busy), 8'h01);
        step();
        chk("s1_grant1_req", 8'(u_if.slot_req), 8'h01);
        chk("s1_grant1_chan", 8'(u_if.slot_chan), 8'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s1_hold_chan", 8'(u_if.slot_chan), 8'h01);
            chk("s1_hold_req", 8'(u_if.slot_req), 8'h01);
        end
        ack_grant();
        chk("s1_pending_after_ack", 8'(pending), 8'h08);
        step();
        chk("s1_grant2_chan", 8'(u_if.slot_chan), 8'h03);
        chk("s1_grant2_req", 8'(u_if.slot_req), 8'h01);
        ack_grant();
        step();
        chk("s1_idle", 8'(busy), 8'h00);

        // Restart flag follows the granted channel only.
        strobe_line(4'b0010, 4'b0010);
        step();
        chk("s2_chan", 8'(u_if.slot_chan), 8'h01);
        chk("s2_restart", 8'(u_if.slot_restart), 8'h01);
        ack_grant(); step();
        strobe_line(4'b0100, 4'b0000);
        step();
        chk("s2_other_chan", 8'(u_if.slot_chan), 8'h02);
        chk("s2_other_restart", 8'(u_if.slot_restart), 8'h00);
        ack_grant(); step();

        // New line during an in-flight grant: leftovers become overruns.
        strobe_line(4'b1100, 4'b0000);
        step();
        chk("s3_inflight_chan", 8'(u_if.slot_chan), 8'h02);
        strobe_line(4'b0001, 4'b0000);
        chk("s3_overrun", 8'(overrun), 8'h08);
        chk("s3_pending", 8'(pending), 8'h01);
        chk("s3_still_req", 8'(u_if.slot_req), 8'h01);
        ack_grant();
        step();
        chk("s3_next_chan", 8'(u_if.slot_chan), 8'h00);
        chk("s3_next_req", 8'(u_if.slot_req), 8'h01);
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        chk("s3_ovr_clr", 8'(overrun), 8'h00);
        ack_grant(); step();

        // No grant while the slot is unavailable or off the colour clock.
        u_if.slot_free = 1'b0;
        strobe_line(4'b0001, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin u_if.slot_free = 1'b1; cck = 1'b0; end
            step();
            chk("s4_no_grant", 8'(u_if.slot_req), 8'h00);
        end
        cck = 1'b1;
        step();
        chk("s4_grant", 8'(u_if.slot_req), 8'h01);
        ack_grant(); step();

        // Reset in WAIT needs no ack; the next line behaves normally.
        strobe_line(4'b0010, 4'b0000);
        step();
        chk("s5_in_wait", 8'(u_if.slot_req), 8'h01);
        reset = 1'b1; step(); reset = 1'b0;
        chk("s5_req", 8'(u_if.slot_req), 8'h00);
        chk("s5_pending", 8'(pending), 8'h00);
        chk("s5_busy", 8'(busy), 8'h00);
        strobe_line(4'b0100, 4'b0000);
        chk("s5_relatch", 8'(pending), 8'h04);
        step();
        chk("s5_regrant", 8'(u_if.slot_chan), 8'h02);
        ack_grant(); step();

        // Global DMA off: strobe still fires, nothing is latched.
        dmaen_master = 1'b0;
        strobe_line(4'b1111, 4'b0000);
        chk("s6_pending", 8'(pending), 8'h00);
        chk("s6_busy", 8'(busy), 8'h00);
        step();
        chk("s6_no_grant", 8'(u_if.slot_req), 8'h00);
        dmaen_master = 1'b1;

        // Clock enable low: no strobe, no register update.
        clk7_en = 1'b0;
        strobe_line(4'b1111, 4'b0000);
        chk("s7_gated_pending", 8'(pending), 8'h00);
        clk7_en = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            clk7_en        = ($urandom_range(7) != 0);
            cck            = $urandom_range(1);
            u_if.slot_free = ($urandom_range(3) != 0);
            u_if.slot_ack  = ($urandom_range(2) == 0);
            line_strobe    = ($urandom_range(11) == 0);
            dmaen_master   = ($urandom_range(9) != 0);
            aud_dmaen      = 4'($urandom);
            dmareq         = 4'($urandom);
            dmas           = 4'($urandom);
            ovr_clr        = ($urandom_range(15) == 0);
            reset          = ($urandom_range(199) == 0);
            #1;
            chk("rnd_strhor", 8'(strhor), 8'(line_strobe & clk7_en & ~reset));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
